// File: rtl/fsm_key_tx.sv
// Transmit side of the byte-stream unlock protocol: streams K[i]^i for i = 0..LEN-1
// over a valid/ready handshake, with start/abort control from a boot or test controller.
module fsm_key_tx #(
  parameter int LEN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       ready,
  output logic [7:0] dout,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] idx
);

  localparam logic [7:0] LAST  = 8'(LEN - 1);
  localparam logic [7:0] LEN_B = 8'(LEN);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  function automatic logic [7:0] key_mask(input logic [7:0] i);
    case (i)
      8'd0:  key_mask = 8'h6A;  8'd1:  key_mask = 8'h74;  8'd2:  key_mask = 8'h71;
      8'd3:  key_mask = 8'h77;  8'd4:  key_mask = 8'h47;  8'd5:  key_mask = 8'h51;
      8'd6:  key_mask = 8'h40;  8'd7:  key_mask = 8'h7C;  8'd8:  key_mask = 8'h5B;
      8'd9:  key_mask = 8'h70;  8'd10: key_mask = 8'h79;  8'd11: key_mask = 8'h7F;
      8'd12: key_mask = 8'h69;  8'd13: key_mask = 8'h60;  8'd14: key_mask = 8'h58;
      8'd15: key_mask = 8'h6A;  8'd16: key_mask = 8'h62;  8'd17: key_mask = 8'h78;
      8'd18: key_mask = 8'h7E;  8'd19: key_mask = 8'h7C;  8'd20: key_mask = 8'h73;
      8'd21: key_mask = 8'h4A;  8'd22: key_mask = 8'h7F;  8'd23: key_mask = 8'h64;
      8'd24: key_mask = 8'h47;  8'd25: key_mask = 8'h73;  8'd26: key_mask = 8'h6F;
      8'd27: key_mask = 8'h68;  8'd28: key_mask = 8'h68;  8'd29: key_mask = 8'h42;
      8'd30: key_mask = 8'h5D;  8'd31: key_mask = 8'h40;  8'd32: key_mask = 8'h57;
      8'd33: key_mask = 8'h48;  8'd34: key_mask = 8'h56;  8'd35: key_mask = 8'h4B;
      8'd36: key_mask = 8'h7B;  8'd37: key_mask = 8'h43;  8'd38: key_mask = 8'h47;
      8'd39: key_mask = 8'h49;  8'd40: key_mask = 8'h4B;  8'd41: key_mask = 8'h50;
      8'd42: key_mask = 8'h75;  8'd43: key_mask = 8'h45;  8'd44: key_mask = 8'h43;
      8'd45: key_mask = 8'h59;  8'd46: key_mask = 8'h4F;  8'd47: key_mask = 8'h5B;
      8'd48: key_mask = 8'h59;  8'd49: key_mask = 8'h5E;  8'd50: key_mask = 8'h5C;
      8'd51: key_mask = 8'h6C;  8'd52: key_mask = 8'h46;  8'd53: key_mask = 8'h5C;
      8'd54: key_mask = 8'h51;  8'd55: key_mask = 8'h5F;  8'd56: key_mask = 8'h4C;
      8'd57: key_mask = 8'h06;  8'd58: key_mask = 8'h47;
      default: key_mask = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] key_byte(input logic [7:0] i);
    key_byte = key_mask(i) ^ i;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dout  <= 8'h00;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort in IDLE does nothing except suppress a same-cycle start
          if (start && !abort) begin
            state <= SEND;
            idx   <= 8'd0;
            dout  <= key_byte(8'd0);
            valid <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
            dout  <= 8'h00;
            valid <= 1'b0;
            busy  <= 1'b0;
            idx   <= 8'd0;
          end else if (valid && ready) begin
            if (idx == LAST) begin
              state <= IDLE;
              dout  <= 8'h00;
              valid <= 1'b0;
              busy  <= 1'b0;
              idx   <= LEN_B;
              done  <= 1'b1;
            end else begin
              idx  <= idx + 8'd1;
              dout <= key_byte(idx + 8'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_key_tx.sv
// Directed bench for fsm_key_tx: full 59-byte run with a lock-step checker model,
// stalls, abort, start/abort interplay, a LEN=4 build and asynchronous reset mid-run.
module tb_fsm_key_tx;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, ready;
  logic [7:0] dout, idx;
  logic       valid, busy, done;

  logic       start4, ready4;
  logic [7:0] dout4, idx4;
  logic       valid4, busy4, done4;

  int n_vec = 0;
  int n_err = 0;

  string key_s = "justCTF{SystemVerilog_is_just_C_with_fancy_notation_right?}";
  int    chk_state;
  logic  done_seen;

  fsm_key_tx #(.LEN(59)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ready(ready),
    .dout(dout), .valid(valid), .busy(busy), .done(done), .idx(idx)
  );

  fsm_key_tx #(.LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(1'b0), .ready(ready4),
    .dout(dout4), .valid(valid4), .busy(busy4), .done(done4), .idx(idx4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] exp_idx);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_dout"},  32'(dout),  32'h00);
    chk({tag, "_idx"},   32'(idx),   32'(exp_idx));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    start4 = 1'b0; ready4 = 1'b1;
    #12;
    chk_idle("reset", 8'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full run, ready tied high, checker model fed in lock-step
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", 32'(valid), 32'd1);
    chk("first_busy",  32'(busy),  32'd1);
    chk("byte0_hand",  32'(dout),  32'h6A);
    chk_state = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 59; i++) begin
      chk($sformatf("run_idx%0d", i),  32'(idx),  32'(i));
      chk($sformatf("run_byte%0d", i), 32'(dout), 32'(key_s[i]));
      if (done) done_seen = 1'b1;
      if (valid && ready) chk_state = (dout == key_s[chk_state]) ? chk_state + 1 : 0;
      tick();
    end
    chk("early_done", 32'(done_seen), 32'd0);
    chk("done_clk60", 32'(done), 32'd1);
    chk_idle("after_run", 8'd59);
    chk("checker_solved", 32'(chk_state), 32'd59);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idx_holds", 32'(idx), 32'd59);

    // Stall at idx 10
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("stall_pre_idx",  32'(idx),  32'd10);
    chk("stall_pre_byte", 32'(dout), 32'h73);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_idx_c%0d", k),   32'(idx),   32'd10);
      chk($sformatf("stall_byte_c%0d", k),  32'(dout),  32'h73);
      chk($sformatf("stall_valid_c%0d", k), 32'(valid), 32'd1);
    end
    ready = 1'b1;
    tick();
    chk("stall_post_idx",  32'(idx),  32'd11);
    chk("stall_post_byte", 32'(dout), 32'h74);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_stall", 8'd0);

    // Abort at idx 20 with a same-cycle transfer
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("abort_pre_idx",  32'(idx),  32'd20);
    chk("abort_pre_byte", 32'(dout), 32'h67);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort20", 8'd0);
    chk("abort20_done", 32'(done), 32'd0);
    done_seen = 1'b0;
    repeat (3) begin
      tick();
      if (done) done_seen = 1'b1;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_byte", 32'(dout), 32'h6A);
    chk("restart_idx",  32'(idx),  32'd0);

    // start held during SEND is ignored
    start = 1'b1;
    repeat (5) tick();
    chk("hold_start_idx",  32'(idx),  32'd5);
    chk("hold_start_byte", 32'(dout), 32'h54);
    abort = 1'b1;
    tick();
    chk_idle("abort_over_start", 8'd0);
    tick();
    chk_idle("start_abort_idle", 8'd0);
    start = 1'b0; abort = 1'b0;

    // LEN=4 build
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("len4_b0", 32'(dout4), 32'h6A);
    tick();
    chk("len4_b1", 32'(dout4), 32'h75);
    tick();
    chk("len4_b2", 32'(dout4), 32'h73);
    tick();
    chk("len4_b3", 32'(dout4), 32'h74);
    chk("len4_nodone", 32'(done4), 32'd0);
    tick();
    chk("len4_done",  32'(done4),  32'd1);
    chk("len4_idx",   32'(idx4),   32'd4);
    chk("len4_valid", 32'(valid4), 32'd0);
    chk("len4_busy",  32'(busy4),  32'd0);

    // Asynchronous reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("mid_pre_idx", 32'(idx), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 8'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk_idle("no_resume", 8'd0);
    chk("no_resume_done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_key_tx.md
Name: fsm_key_tx

Overview:
- Transmit side of the byte-stream unlock protocol. Emits the 59-byte key sequence that drives the byte-stream FSM checker from state 0 to its solved state 59.
- Each byte goes out on a valid/ready stream. For direct lock-step connection to the checker, tie ready high: the checker consumes one byte per clock and resets to state 0 on any mismatch.
- Sits between a test/boot controller (start/abort) and the checker's di input.

Parameters:
- LEN, 59, number of bytes emitted per run; legal range 1..59; LEN < 59 emits a prefix of the sequence.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel a run in progress
- ready  in  1  downstream accepts the current byte
- do  out  8  key byte
- valid  out  1  do holds a valid byte
- busy  out  1  run in progress (SEND state)
- done  out  1  one-cycle pulse after the last byte is accepted
- idx  out  8  index of the current byte; mirrors the checker's state value

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: do=0x00, valid=0, busy=0, done=0, idx=0, state=IDLE.
- Key function: do = K[idx] ^ idx[7:0].
- Mask table K[0..58], hex:
  - 6A 74 71 77 47 51 40 7C 5B 70 79 7F 69 60 58 6A 62 78 7E 7C
  - 73 4A 7F 64 47 73 6F 68 68 42 5D 40 57 48 56 4B 7B 43 47 49
  - 4B 50 75 45 43 59 4F 5B 59 5E 5C 6C 46 5C 51 5F 4C 06 47
- Implement K as a constant case ROM.
- States: IDLE, SEND.
- IDLE:
  - do=0x00, valid=0, busy=0.
  - start=1 (and abort=0): next cycle state=SEND, idx=0, valid=1, busy=1, do=K[0]^0=0x6A.
  - idx holds its last value until a new start.
- SEND:
  - Transfer occurs when valid&&ready on a rising edge.
  - Transfer with idx<LEN-1: next cycle idx=idx+1, do=K[idx+1]^(idx+1), valid stays 1.
  - Transfer with idx==LEN-1: next cycle state=IDLE, valid=0, busy=0, do=0x00, idx=LEN, done=1 for exactly one cycle.
  - ready=0: do, idx, valid hold unchanged (stall). No bubble is inserted when ready is high continuously, so throughput is 1 byte/clk.
  - start is ignored while in SEND.
- abort=1 in SEND:
  - Next cycle state=IDLE, valid=0, busy=0, do=0x00, idx=0, no done pulse.
  - Abort wins over a same-cycle transfer and over start.
  - abort in IDLE has no effect and blocks a same-cycle start.
- Latency: start to first valid byte is 1 clk; start to done is LEN+1 clk with ready tied high.
- idx width is 8 bits. idx never exceeds LEN, so there is no wrap.
- Asynchronous reset mid-run forces all reset values immediately. No done pulse is produced, and the run does not resume.

Test Plan:
- Reset, start pulse, ready=1 -> valid on clk 1; do sequence begins 6A 75 73 74 43 ("justC"); byte 57=0x3F, byte 58=0x7D; done pulses on clk 60; valid low after; idx=59.
- Same run with do fed into the checker's di in lock-step -> checker solved=1 on the cycle after the last byte; solved never asserts if any single byte is corrupted.
- ready toggled 1,0,0,1 at idx=10 -> do=0x73 held for the 3 cycles, idx=10 held, then idx=11 with do=0x74; no byte lost or duplicated.
- abort asserted at idx=20 with ready=1 -> next cycle valid=0, idx=0, busy=0, done never pulses; a following start restarts at do=0x6A.
- start held high during SEND plus start and abort together in IDLE -> no restart mid-run; simultaneous case stays IDLE.
- LEN=4 build -> emits 6A 75 73 74, done on clk 5, idx=4; rst_n pulsed low mid-run -> outputs return to reset values asynchronously.
